// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, RAM geometry defaults and RGB565 -> RGB121 field positions
package cam_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE, DONE} cam_state_e;
    localparam int CAM_ADDR_WIDTH = 7;
    localparam int CAM_MEM_DEPTH  = 120;
    // bit positions of R[4], G[5], G[4] in the first byte and B[4] in the second byte
    localparam int R4_BIT = 7;
    localparam int G5_BIT = 2;
    localparam int G4_BIT = 1;
    localparam int B4_BIT = 4;
    function automatic logic [3:0] rgb121(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[R4_BIT], b0[G5_BIT], b0[G4_BIT], b1[B4_BIT]};
    endfunction
endpackage

// File: rtl/cam_if.sv
// cam_if: camera parallel bus plus frame-RAM write port; slave side is the capture stage
interface cam_if import cam_pkg::*; #(parameter int ADDR_WIDTH = CAM_ADDR_WIDTH);
    logic                  cam_pclk;
    logic                  cam_vsync;
    logic                  cam_href;
    logic [7:0]            cam_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_data;
    modport master (output cam_pclk, cam_vsync, cam_href, cam_data, input mem_we, mem_addr, mem_data);
    modport slave (input cam_pclk, cam_vsync, cam_href, cam_data, output mem_we, mem_addr, mem_data);
endinterface

// File: rtl/cam_sync.sv
// cam_sync: two-flop sampling of the camera bus, kept aligned, plus edge detectors
//  qualified by the pclk rising edge so every bus decision sees one consistent sample.
module cam_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       pclk_i,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] data_i,
    output logic       pclk_rise_o,
    output logic       href_o,
    output logic [7:0] data_o,
    output logic       vsync_rise_o,
    output logic       vsync_fall_o,
    output logic       href_fall_o
);
    logic [10:0] s1_q, s2_q;
    logic        pclk3_q, vsync_p_q, href_p_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            pclk3_q   <= 1'b0;
            vsync_p_q <= 1'b0;
            href_p_q  <= 1'b0;
        end else begin
            s1_q    <= {pclk_i, vsync_i, href_i, data_i};
            s2_q    <= s1_q;
            pclk3_q <= s2_q[10];
            if (pclk_rise_o) begin
                vsync_p_q <= s2_q[9];
                href_p_q  <= s2_q[8];
            end
        end
    end

    assign pclk_rise_o  = s2_q[10] & ~pclk3_q;
    assign href_o       = s2_q[8];
    assign data_o       = s2_q[7:0];
    assign vsync_rise_o = pclk_rise_o & s2_q[9] & ~vsync_p_q;
    assign vsync_fall_o = pclk_rise_o & ~s2_q[9] & vsync_p_q;
    assign href_fall_o  = pclk_rise_o & ~s2_q[8] & href_p_q;
endmodule

// File: rtl/cam_capture.sv
// cam_capture: one-frame-per-start camera capture; assembles RGB565 pixels, decimates,
//  reduces to RGB121 and streams write strobes into the frame RAM.
module cam_capture import cam_pkg::*; #(
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int MEM_DEPTH  = CAM_MEM_DEPTH,
    parameter int H_DECIM    = 4,
    parameter int V_DECIM    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    cam_if.slave                cam,
    output logic                busy,
    output logic                done,
    output logic [ADDR_WIDTH:0] pix_count
);
    localparam int CW    = H_DECIM > 1 ? $clog2(H_DECIM) : 1;
    localparam int LW    = V_DECIM > 1 ? $clog2(V_DECIM) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]    COL_MAX  = CW'(H_DECIM - 1);
    localparam logic [LW-1:0]    LINE_MAX = LW'(V_DECIM - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MEM_DEPTH);

    cam_state_e            state_q, state_d;
    logic                  phase_q, phase_d;
    logic [7:0]            byte0_q, byte0_d;
    logic [CW-1:0]         col_q, col_d;
    logic [LW-1:0]         line_q, line_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  pclk_rise, href_s, vsync_rise, vsync_fall, href_fall, pix_done;
    logic [7:0]            data_s;

    cam_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .pclk_i      (cam.cam_pclk),
        .vsync_i     (cam.cam_vsync),
        .href_i      (cam.cam_href),
        .data_i      (cam.cam_data),
        .pclk_rise_o (pclk_rise),
        .href_o      (href_s),
        .data_o      (data_s),
        .vsync_rise_o(vsync_rise),
        .vsync_fall_o(vsync_fall),
        .href_fall_o (href_fall)
    );

    assign pix_done = pclk_rise & href_s & phase_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            byte0_q <= '0;
            col_q   <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte0_q <= byte0_d;
            col_q   <= col_d;
            line_q  <= line_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // address and count advance in the cycle after each strobe, so mem_addr == pix_count during it
    always_comb begin
        state_d = state_q;
        phase_d = pclk_rise ? (href_s & ~phase_q) : phase_q;
        byte0_d = (pclk_rise & href_s & ~phase_q) ? data_s : byte0_q;
        col_d   = pix_done ? (col_q == COL_MAX ? '0 : col_q + CW'(1)) : col_q;
        line_d  = line_q;
        we_d    = 1'b0;
        addr_d  = addr_q + ADDR_WIDTH'(we_q);
        cnt_d   = cnt_q + CNT_W'(we_q);
        data_d  = data_q;
        done_d  = done_q;
        if (href_fall) begin
            col_d  = '0;
            line_d = line_q == LINE_MAX ? '0 : line_q + LW'(1);
        end
        if (pix_done && state_q == CAPTURE && col_q == '0 && line_q == '0 && cnt_q < DEPTH) begin
            we_d   = 1'b1;
            data_d = rgb121(byte0_q, data_s);
        end
        if ((state_q == IDLE || state_q == DONE) && start) begin
            state_d = WAIT_VSYNC;
            done_d  = 1'b0;
            cnt_d   = '0;
            addr_d  = '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else if (state_q == WAIT_VSYNC && vsync_fall) begin
            state_d = CAPTURE;
            col_d   = '0;
            line_d  = '0;
        end else if (state_q == CAPTURE && (vsync_rise || cnt_q == DEPTH)) begin
            state_d = DONE;
        end
    end

    assign cam.mem_we   = we_q;
    assign cam.mem_addr = addr_q;
    assign cam.mem_data = data_q;
    assign busy         = state_q == WAIT_VSYNC || state_q == CAPTURE;
    assign done         = done_q;
    assign pix_count    = cnt_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: two capture instances (4x4 and 1x1 decimation) share one camera model;
//  a frame-level model predicts every RAM write and the end-of-frame status.
module tb_cam_capture;
    localparam int DEPTH = 120;

    logic       clk, reset, pclk, vsync, href, start_a, start_b;
    logic [7:0] data;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] cnt_a, cnt_b;

    cam_if #(.ADDR_WIDTH(7)) ifa ();
    cam_if #(.ADDR_WIDTH(7)) ifb ();
    assign ifa.cam_pclk  = pclk;
    assign ifa.cam_vsync = vsync;
    assign ifa.cam_href  = href;
    assign ifa.cam_data  = data;
    assign ifb.cam_pclk  = pclk;
    assign ifb.cam_vsync = vsync;
    assign ifb.cam_href  = href;
    assign ifb.cam_data  = data;

    cam_capture #(.ADDR_WIDTH(7), .MEM_DEPTH(DEPTH), .H_DECIM(4), .V_DECIM(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cam(ifa.slave),
        .busy(busy_a), .done(done_a), .pix_count(cnt_a));
    cam_capture #(.ADDR_WIDTH(7), .MEM_DEPTH(DEPTH), .H_DECIM(1), .V_DECIM(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cam(ifb.slave),
        .busy(busy_b), .done(done_b), .pix_count(cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit m_busy[2], m_cap[2], m_done[2];
    int m_cnt[2], last_addr[2], last_data[2];
    int qa[$], qb[$];

    function automatic int hdec(input int d); return d == 0 ? 4 : 1; endfunction
    function automatic int vdec(input int d); return d == 0 ? 4 : 1; endfunction

    function automatic logic [3:0] ref_pix(input logic [7:0] b0, input logic [7:0] b1);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = b0[7:3];
        g = {b0[2:0], b1[7:5]};
        b = b1[4:0];
        return {r[4], g[5], g[4], b[4]};
    endfunction

    function automatic logic [7:0] pat(input int mode, input int l, input int p, input int half);
        if (mode == 0) return half == 1 ? 8'h1F : 8'hF8;
        return 8'(l * 29 + p * 7 + half * 101 + 3);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_write(input int d, input logic [6:0] a, input logic [3:0] dat);
        int e, n;
        n = d == 0 ? qa.size() : qb.size();
        n_chk++;
        if (n == 0) begin
            n_fail++;
            $display("FAIL write%0d unexpected: addr %0d data %0d, want no write", d, a, dat);
        end else begin
            if (d == 0) e = qa.pop_front();
            else e = qb.pop_front();
            if ({a, dat} != e[10:0]) begin
                n_fail++;
                $display("FAIL write%0d: addr %0d data %0d, want addr %0d data %0d", d, a, dat, e >> 4, e & 15);
            end
        end
        last_addr[d] = int'(a);
        last_data[d] = int'(dat);
    endtask

    always @(negedge clk) begin
        if (ifa.mem_we === 1'b1) chk_write(0, ifa.mem_addr, ifa.mem_data);
        if (ifb.mem_we === 1'b1) chk_write(1, ifb.mem_addr, ifb.mem_data);
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_cap[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic model_start(input logic [1:0] st);
        for (int d = 0; d < 2; d++)
            if (st[d] && !m_busy[d]) begin
                m_busy[d] = 1; m_cap[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
            end
    endtask

    task automatic model_vfall();
        for (int d = 0; d < 2; d++) if (m_busy[d] && !m_cap[d]) m_cap[d] = 1;
    endtask

    task automatic model_vrise();
        for (int d = 0; d < 2; d++)
            if (m_cap[d]) begin
                m_cap[d] = 0; m_busy[d] = 0; m_done[d] = 1;
            end
    endtask

    task automatic model_pix(input int l, input int p, input logic [7:0] b0, input logic [7:0] b1);
        int e;
        for (int d = 0; d < 2; d++)
            if (m_cap[d] && l % vdec(d) == 0 && p % hdec(d) == 0 && m_cnt[d] < DEPTH) begin
                e = (m_cnt[d] << 4) | int'(ref_pix(b0, b1));
                if (d == 0) qa.push_back(e);
                else qb.push_back(e);
                m_cnt[d]++;
                if (m_cnt[d] == DEPTH) begin
                    m_cap[d] = 0; m_busy[d] = 0; m_done[d] = 1;
                end
            end
    endtask

    // one pclk period = 4 clk; start pulses 1 clk, reset is held for 3 clk
    task automatic cam_cycle(input logic vs, input logic hr, input logic [7:0] d, input logic [1:0] st, input bit rs);
        @(negedge clk);
        pclk = 1'b0; vsync = vs; href = hr; data = d;
        start_a = st[0]; start_b = st[1];
        if (rs) begin
            reset = 1'b1;
            model_reset();
        end
        model_start(st);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        pclk = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we_a"}, int'(ifa.mem_we), 0);
        chk({tag, "_addr_a"}, int'(ifa.mem_addr), 0);
        chk({tag, "_data_a"}, int'(ifa.mem_data), 0);
        chk({tag, "_busy_a"}, int'(busy_a), 0);
        chk({tag, "_done_a"}, int'(done_a), 0);
        chk({tag, "_cnt_a"}, int'(cnt_a), 0);
        chk({tag, "_we_b"}, int'(ifb.mem_we), 0);
        chk({tag, "_addr_b"}, int'(ifb.mem_addr), 0);
        chk({tag, "_data_b"}, int'(ifb.mem_data), 0);
        chk({tag, "_busy_b"}, int'(busy_b), 0);
        chk({tag, "_done_b"}, int'(done_b), 0);
        chk({tag, "_cnt_b"}, int'(cnt_b), 0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_busy_a"}, int'(busy_a), int'(m_busy[0]));
        chk({tag, "_done_a"}, int'(done_a), int'(m_done[0]));
        chk({tag, "_cnt_a"}, int'(cnt_a), m_cnt[0]);
        chk({tag, "_pend_a"}, qa.size(), 0);
        chk({tag, "_busy_b"}, int'(busy_b), int'(m_busy[1]));
        chk({tag, "_done_b"}, int'(done_b), int'(m_done[1]));
        chk({tag, "_cnt_b"}, int'(cnt_b), m_cnt[1]);
        chk({tag, "_pend_b"}, qb.size(), 0);
    endtask

    task automatic frame(input int w, input int h, input int mode, input bit odd, input logic [1:0] pre,
                         input int st_line, input logic [1:0] st_mask, input int rst_line);
        logic [7:0] b0, bv;
        int nb;
        b0 = 8'h00;
        cam_cycle(1'b1, 1'b0, 8'h00, pre, 1'b0);
        repeat (2) cam_cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        model_vfall();
        repeat (2) cam_cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        for (int l = 0; l < h; l++) begin
            nb = (odd && l % 2 == 0) ? 3 : 2 * w;
            for (int b = 0; b < nb; b++) begin
                bv = pat(mode, l, b / 2, b % 2);
                cam_cycle(1'b0, 1'b1, bv, (l == st_line && b == 0) ? st_mask : 2'b00, l == rst_line && b == 0);
                if (l == rst_line && b == 0) chk_zero("rst_mid");
                if (b % 2 == 0) b0 = bv;
                else model_pix(l, b / 2, b0, bv);
            end
            repeat (2) cam_cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        end
        model_vrise();
        repeat (3) cam_cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    endtask

    initial begin
        pclk = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
        start_a = 1'b0; start_b = 1'b0; reset = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // 16x8 frame of 0xF8,0x1F into the 4x4-decimating instance
        frame(16, 8, 0, 1'b0, 2'b01, -1, 2'b00, -1);
        chk_model("t2");
        chk("t2_cnt_lit", int'(cnt_a), 8);
        chk("t2_done_lit", int'(done_a), 1);
        chk("t2_last_addr_lit", last_addr[0], 7);
        chk("t2_last_data_lit", last_data[0], 9);

        // 32x8 full-rate frame: stops at the RAM depth
        frame(32, 8, 1, 1'b0, 2'b10, -1, 2'b00, -1);
        chk_model("t3");
        chk("t3_cnt_lit", int'(cnt_b), 120);
        chk("t3_last_addr_lit", last_addr[1], 119);
        chk("t3_busy_lit", int'(busy_b), 0);

        // start pulsed while capturing is ignored
        frame(16, 8, 1, 1'b0, 2'b01, 2, 2'b01, -1);
        chk_model("t4");
        chk("t4_cnt_lit", int'(cnt_a), 8);

        // start mid-frame waits for the next frame
        frame(16, 8, 1, 1'b0, 2'b00, 3, 2'b01, -1);
        chk_model("t5a");
        chk("t5a_busy_lit", int'(busy_a), 1);
        chk("t5a_cnt_lit", int'(cnt_a), 0);
        frame(16, 8, 1, 1'b0, 2'b00, -1, 2'b00, -1);
        chk_model("t5b");
        chk("t5b_cnt_lit", int'(cnt_a), 8);

        // even lines carry 3 bytes: one pixel, trailing byte dropped
        frame(8, 8, 1, 1'b1, 2'b11, -1, 2'b00, -1);
        chk_model("t6");
        chk("t6_cnt_a_lit", int'(cnt_a), 2);
        chk("t6_cnt_b_lit", int'(cnt_b), 36);

        // reset in the middle of a capture
        frame(16, 8, 1, 1'b0, 2'b11, -1, 2'b00, 5);
        chk_model("t1");
        chk("t1_cnt_a_lit", int'(cnt_a), 0);
        chk("t1_cnt_b_lit", int'(cnt_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
